fetch8: RTL and testbench

Instruction fetch stage for the 8-word CPU memory. Walks a 3-bit program counter, issues one read per cycle to the memory, and queues returned words in a 2-entry buffer. Hands words to the decoder over a valid/ready handshake and supports redirect (branch/jump) and halt.

---
 rtl/fetch8_pkg.sv | 13 +
 rtl/fetch8_buf2.sv | 68 ++++++
 rtl/fetch8.sv | 100 ++++++++++
 tb/tb_fetch8.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fetch8_pkg.sv
// Shared CPU package: fetch FSM state encoding and default bus widths.
package fetch8_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/fetch8_buf2.sv
// Two-entry FIFO holding fetched words with their fetch address as a tag.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_buf2 #(
  parameter int DW = 32,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [TW-1:0] push_tag,
  input  logic          pop,
  output logic [1:0]    count,
  output logic          head_valid,
  output logic [DW-1:0] head_data,
  output logic [TW-1:0] head_tag
);

  logic [DW-1:0] data_reg [2];
  logic [TW-1:0] tag_reg  [2];
  logic [1:0]    count_reg;
  logic [1:0]    count_next;
  logic          pop_eff;
  logic          wr_sel;

  // A pop on an empty buffer is ignored; the write slot is the first free
  // entry after any shift caused by a same-cycle pop.
  always_comb begin
    pop_eff    = pop && (count_reg != 2'd0);
    wr_sel     = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop_eff);
    count_next = count_reg;
    if (push && !pop_eff)      count_next = count_reg + 2'd1;
    else if (!push && pop_eff) count_next = count_reg - 2'd1;
  end

  // Storage and occupancy; flush empties the buffer regardless of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      data_reg[0] <= '0;
      data_reg[1] <= '0;
      tag_reg[0]  <= '0;
      tag_reg[1]  <= '0;
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      if (pop_eff) begin
        data_reg[0] <= data_reg[1];
        tag_reg[0]  <= tag_reg[1];
      end
      if (push) begin
        data_reg[wr_sel] <= push_data;
        tag_reg[wr_sel]  <= push_tag;
      end
      count_reg <= count_next;
    end
  end

  // Head is forced to zero when empty so stale words never leak out.
  always_comb begin
    count      = count_reg;
    head_valid = (count_reg != 2'd0);
    head_data  = head_valid ? data_reg[0] : '0;
    head_tag   = head_valid ? tag_reg[0]  : '0;
  end

endmodule

// File: rtl/fetch8.sv
// Instruction fetch stage: FSM, program counter and issue logic in front of
// a 2-entry word buffer that feeds the decoder over valid/ready.
module fetch8
  import fetch8_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              busy
);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              busy_reg;
  logic [1:0]        count;
  logic              pop;
  logic              fetch;

  // Issue only in RUN, never alongside halt or redirect, and only when a
  // slot is free now or is being freed by this cycle's pop.
  always_comb begin
    pop      = instr_valid && instr_ready;
    fetch    = (state_reg == RUN) && !halt && !redirect_valid &&
               ((count < 2'd2) || pop);
    mem_rd   = fetch;
    mem_addr = fetch ? pc_reg : '0;
    busy     = busy_reg;
  end

  // Control FSM and program counter; redirect overrides the PC everywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect_valid) pc_reg <= redirect_pc;
          else if (start)     pc_reg <= RESET_PC;
          if (start) begin
            state_reg <= halt ? HALTED : RUN;
            busy_reg  <= !halt;
          end
        end
        RUN: begin
          if (redirect_valid) pc_reg <= redirect_pc;
          else if (fetch)     pc_reg <= pc_reg + ADDR_W'(1);
          if (halt) begin
            state_reg <= HALTED;
            busy_reg  <= 1'b0;
          end
        end
        HALTED: begin
          if (redirect_valid) pc_reg <= redirect_pc;
          if (start && !halt) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  fetch_buf2 #(
    .DW(DATA_W),
    .TW(ADDR_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (fetch),
    .push_data  (mem_rdata),
    .push_tag   (pc_reg),
    .pop        (pop),
    .count      (count),
    .head_valid (instr_valid),
    .head_data  (instr),
    .head_tag   (instr_pc)
  );

endmodule

// File: tb/tb_fetch8.sv
// Directed bench for fetch8 with a combinational memory holding 0x100+addr.
module tb_fetch8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, redirect_valid, instr_ready;
  logic [2:0]  redirect_pc;
  logic        mem_rd;
  logic [2:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [2:0]  instr_pc;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_rdata = 32'h100 + {29'd0, mem_addr};

  fetch8 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, {29'd0, mem_addr}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, {29'd0, instr_pc}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 3'd0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    $display("step reset: outputs at reset values");
    rst_n = 1'b1;
    tick;
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Start with ready held high: 2-cycle latency, then one word per cycle.
    instr_ready = 1'b1; start = 1'b1;
    #1;
    chk("idle_no_rd", {31'd0, mem_rd}, 32'd0);
    tick; start = 1'b0; #1;
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_rd", {31'd0, mem_rd}, 32'd1);
    chk("start_addr", {29'd0, mem_addr}, 32'd0);
    chk("start_novalid", {31'd0, instr_valid}, 32'd0);
    tick;
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", instr, 32'h100);
    chk("first_pc", {29'd0, instr_pc}, 32'd0);
    chk("first_next_addr", {29'd0, mem_addr}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick;
      chk($sformatf("stream_instr%0d", i), instr, 32'h100 + 32'(i % 8));
      chk($sformatf("stream_pc%0d", i), {29'd0, instr_pc}, 32'(i % 8));
      $display("step stream %0d: instr=%0h pc=%0d", i, instr, instr_pc);
    end

    // Halt with one word buffered: no fetch, word drains on ready.
    instr_ready = 1'b0; halt = 1'b1; #1;
    chk("halt_no_rd", {31'd0, mem_rd}, 32'd0);
    tick; halt = 1'b0; #1;
    chk("halted_busy", {31'd0, busy}, 32'd0);
    chk("halted_no_rd", {31'd0, mem_rd}, 32'd0);
    chk("halted_instr", instr, 32'h100);
    tick;
    chk("halted_hold", instr, 32'h100);
    instr_ready = 1'b1; #1;
    chk("drain_no_rd", {31'd0, mem_rd}, 32'd0);
    tick;
    chk("drained_valid", {31'd0, instr_valid}, 32'd0);
    chk("drained_instr", instr, 32'd0);
    $display("step halt: drained buffered word");

    // Resume at saved pc 1 under backpressure: exactly two fetches.
    instr_ready = 1'b0; start = 1'b1;
    tick; start = 1'b0; #1;
    chk("resume_rd", {31'd0, mem_rd}, 32'd1);
    chk("resume_addr", {29'd0, mem_addr}, 32'd1);
    tick;
    chk("bp1_instr", instr, 32'h101);
    chk("bp1_addr", {29'd0, mem_addr}, 32'd2);
    tick;
    chk("bp_full_no_rd", {31'd0, mem_rd}, 32'd0);
    tick;
    chk("bp_hold_no_rd", {31'd0, mem_rd}, 32'd0);
    chk("bp_hold_instr", instr, 32'h101);
    chk("bp_hold_pc", {29'd0, instr_pc}, 32'd1);
    $display("step resume: backpressure holds at 2 words");

    // Redirect to 5 with a full buffer and a pop in the same cycle.
    redirect_valid = 1'b1; redirect_pc = 3'd5; instr_ready = 1'b1; #1;
    chk("redir_no_rd", {31'd0, mem_rd}, 32'd0);
    tick; redirect_valid = 1'b0; #1;
    chk("redir_flushed", {31'd0, instr_valid}, 32'd0);
    chk("redir_rd", {31'd0, mem_rd}, 32'd1);
    chk("redir_addr", {29'd0, mem_addr}, 32'd5);
    tick;
    chk("redir_instr", instr, 32'h105);
    chk("redir_pc", {29'd0, instr_pc}, 32'd5);
    $display("step redirect: delivered %0h", instr);

    // Halt and redirect to 3 together, then start.
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 3'd3; #1;
    chk("hr_no_rd", {31'd0, mem_rd}, 32'd0);
    tick; halt = 1'b0; redirect_valid = 1'b0; #1;
    chk("hr_busy", {31'd0, busy}, 32'd0);
    chk("hr_empty", {31'd0, instr_valid}, 32'd0);
    start = 1'b1;
    tick; start = 1'b0; #1;
    chk("hr_start_addr", {29'd0, mem_addr}, 32'd3);
    tick;
    chk("hr_instr", instr, 32'h103);
    chk("hr_pc", {29'd0, instr_pc}, 32'd3);
    $display("step halt+redirect: delivered %0h", instr);

    // Fill the buffer, then reset while count=2 and a fetch is issuing.
    instr_ready = 1'b0;
    tick;
    instr_ready = 1'b1; #1;
    chk("pre_rst_rd", {31'd0, mem_rd}, 32'd1);
    chk("pre_rst_addr", {29'd0, mem_addr}, 32'd5);
    rst_n = 1'b0; #1;
    chk_reset_outputs("async_rst");
    tick;
    rst_n = 1'b1;
    tick; tick;
    chk_reset_outputs("post_rst_idle");
    $display("step reset mid-run: outputs cleared, stays idle");

    // Backpressure from address 0 after reset, then deliver in order.
    instr_ready = 1'b0; start = 1'b1;
    tick; start = 1'b0; #1;
    chk("bp0_addr0", {29'd0, mem_addr}, 32'd0);
    tick;
    chk("bp0_addr1", {29'd0, mem_addr}, 32'd1);
    tick;
    chk("bp0_no_rd", {31'd0, mem_rd}, 32'd0);
    chk("bp0_head", instr, 32'h100);
    instr_ready = 1'b1; #1;
    chk("bp0_refill_addr", {29'd0, mem_addr}, 32'd2);
    tick;
    chk("bp0_instr1", instr, 32'h101);
    tick;
    chk("bp0_instr2", instr, 32'h102);
    chk("bp0_pc2", {29'd0, instr_pc}, 32'd2);
    $display("step backpressure: delivered 100,101,102 in order");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
